// File: rtl/otter_pkg.sv
// Shared definitions for the Otter fetch/decode datapath: data width,
// the canonical NOP encoding, and the {PC, IR} entry carried by the fetch queue.
package otter_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fq_entry_t;

endpackage : otter_pkg

// File: rtl/otter_fetch_queue_chk.sv
// Simulation-only property checker for otter_fetch_queue, attached to the
// queue's ports: occupancy bound, no enqueue while full, head stable while stalled.
module otter_fetch_queue_chk #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     FLUSH,
    input  logic                     IMEM_VALID,
    input  logic                     IMEM_READY,
    input  logic                     ID_VALID,
    input  logic [XLEN-1:0]          ID_PC,
    input  logic [XLEN-1:0]          ID_IR,
    input  logic                     ID_READY,
    input  logic [$clog2(DEPTH):0]   COUNT
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            stall_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ir_q;

    // Remember whether the head was stalled across the last edge, and its value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_q <= 1'b0;
            pc_q    <= {XLEN{1'b0}};
            ir_q    <= {XLEN{1'b0}};
        end else begin
            stall_q <= ID_VALID && !ID_READY && !FLUSH;
            pc_q    <= ID_PC;
            ir_q    <= ID_IR;
        end
    end

    // Evaluate the properties mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (RST_N) begin
            a_count_bound: assert (COUNT <= CW'(DEPTH))
                else $error("count above depth: %0d", COUNT);
            a_no_enq_full: assert (!(IMEM_VALID && IMEM_READY && COUNT == CW'(DEPTH)))
                else $error("enqueue accepted while full");
            if (stall_q) begin
                a_stall_stable: assert (ID_VALID && ID_PC == pc_q && ID_IR == ir_q)
                    else $error("head changed while stalled");
            end
        end
    end

endmodule : otter_fetch_queue_chk

// File: rtl/otter_fetch_queue.sv
// Fetch queue between instruction memory and decode. Holds {PC, IR} pairs so
// fetch can run ahead while decode stalls; FLUSH drops every queued entry
// (and any same-cycle enqueue) so wrong-path instructions never reach decode.
// IMEM_READY and ID_VALID are flops derived from next-state occupancy, so
// neither has a combinational path from the handshake inputs.
module otter_fetch_queue
    import otter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     FLUSH,
    input  logic                     IMEM_VALID,
    input  logic [XLEN-1:0]          IMEM_PC,
    input  logic [XLEN-1:0]          IMEM_IR,
    output logic                     IMEM_READY,
    output logic                     ID_VALID,
    output logic [XLEN-1:0]          ID_PC,
    output logic [XLEN-1:0]          ID_IR,
    input  logic                     ID_READY,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              ready_q,  ready_d;
    logic              valid_q,  valid_d;
    logic              enq_s;
    logic              deq_s;

    assign enq_s = IMEM_VALID & ready_q;
    assign deq_s = valid_q & ID_READY;

    // Next-state pointers, occupancy and the registered handshake flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d != CW'(DEPTH));
        valid_d = (count_d != CW'(0));
    end

    // Pointer, occupancy and handshake-flag state with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge CLK) begin
        if (enq_s && !FLUSH) begin
            mem_q[wr_ptr_q] <= '{pc: IMEM_PC, ir: IMEM_IR};
        end
    end

    // Head-of-queue mux; an empty queue presents PC 0 and a NOP to decode.
    always_comb begin
        if (valid_q) begin
            ID_PC = mem_q[rd_ptr_q].pc;
            ID_IR = mem_q[rd_ptr_q].ir;
        end else begin
            ID_PC = {XLEN{1'b0}};
            ID_IR = NOP_INSTR;
        end
    end

    assign IMEM_READY = ready_q;
    assign ID_VALID   = valid_q;
    assign COUNT      = count_q;

endmodule : otter_fetch_queue

// File: tb/tb_otter_fetch_queue.sv
// Self-checking bench for otter_fetch_queue: directed vector table, wrap and
// async-reset sequences, then random traffic against a queue-based model.
module tb_otter_fetch_queue;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        FLUSH;
    logic        IMEM_VALID;
    logic [31:0] IMEM_PC;
    logic [31:0] IMEM_IR;
    logic        IMEM_READY;
    logic        ID_VALID;
    logic [31:0] ID_PC;
    logic [31:0] ID_IR;
    logic        ID_READY;
    logic [1:0]  COUNT;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] model[$];

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        idr;
        logic [31:0] e_cnt;
        logic        e_v;
        logic        e_rdy;
        logic [31:0] e_pc;
        logic [31:0] e_ir;
    } vec_t;

    vec_t tbl[13];

    otter_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .IMEM_VALID(IMEM_VALID), .IMEM_PC(IMEM_PC), .IMEM_IR(IMEM_IR),
        .IMEM_READY(IMEM_READY), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_IR(ID_IR), .ID_READY(ID_READY), .COUNT(COUNT)
    );

    otter_fetch_queue_chk #(.DEPTH(DEPTH), .XLEN(32)) u_chk (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .IMEM_VALID(IMEM_VALID), .IMEM_READY(IMEM_READY), .ID_VALID(ID_VALID),
        .ID_PC(ID_PC), .ID_IR(ID_IR), .ID_READY(ID_READY), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic fl, iv, input logic [31:0] pc, ir,
                                input logic idr, input logic [31:0] e_cnt,
                                input logic e_v, e_rdy, input logic [31:0] e_pc, e_ir);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.ir = ir; v.idr = idr;
        v.e_cnt = e_cnt; v.e_v = e_v; v.e_rdy = e_rdy; v.e_pc = e_pc; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs (called #1 after a rising edge), advance the model.
    task automatic step(input logic fl, iv, input logic [31:0] pc, ir, input logic idr);
        bit m_enq, m_deq;
        FLUSH = fl; IMEM_VALID = iv; IMEM_PC = pc; IMEM_IR = ir; ID_READY = idr;
        m_enq = iv && (model.size() < DEPTH);
        m_deq = idr && (model.size() > 0);
        @(posedge CLK);
        #1;
        if (fl) begin
            model.delete();
        end else begin
            if (m_deq) void'(model.pop_front());
            if (m_enq) model.push_back({pc, ir});
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] e_pc, e_ir;
        e_pc = (model.size() > 0) ? model[0][63:32] : 32'h0;
        e_ir = (model.size() > 0) ? model[0][31:0]  : NOP;
        chk({tag, "_cnt"}, 32'(COUNT), 32'(model.size()));
        chk({tag, "_valid"}, 32'(ID_VALID), 32'(model.size() > 0));
        chk({tag, "_ready"}, 32'(IMEM_READY), 32'(model.size() < DEPTH));
        chk({tag, "_pc"}, ID_PC, e_pc);
        chk({tag, "_ir"}, ID_IR, e_ir);
    endtask

    initial begin
        // Directed table: basic flow, full/backpressure, full with same-cycle traffic, flush.
        tbl[0]  = mk(0, 1, 32'h000, 32'h0050_0093, 1, 1, 1, 1, 32'h000, 32'h0050_0093);
        tbl[1]  = mk(0, 0, 32'h000, 32'h0,         1, 0, 0, 1, 32'h000, NOP);
        tbl[2]  = mk(0, 1, 32'h000, 32'h1110_0013, 0, 1, 1, 1, 32'h000, 32'h1110_0013);
        tbl[3]  = mk(0, 1, 32'h004, 32'h2220_0013, 0, 2, 1, 0, 32'h000, 32'h1110_0013);
        tbl[4]  = mk(0, 1, 32'h008, 32'h3330_0013, 0, 2, 1, 0, 32'h000, 32'h1110_0013);
        tbl[5]  = mk(0, 1, 32'h008, 32'h3330_0013, 1, 1, 1, 1, 32'h004, 32'h2220_0013);
        tbl[6]  = mk(0, 1, 32'h008, 32'h3330_0013, 1, 1, 1, 1, 32'h008, 32'h3330_0013);
        tbl[7]  = mk(0, 0, 32'h000, 32'h0,         1, 0, 0, 1, 32'h000, NOP);
        tbl[8]  = mk(0, 1, 32'h010, 32'h4440_0013, 0, 1, 1, 1, 32'h010, 32'h4440_0013);
        tbl[9]  = mk(0, 1, 32'h014, 32'h5550_0013, 0, 2, 1, 0, 32'h010, 32'h4440_0013);
        tbl[10] = mk(1, 1, 32'h100, 32'h6660_0013, 0, 0, 0, 1, 32'h000, NOP);
        tbl[11] = mk(0, 1, 32'h100, 32'h6660_0013, 0, 1, 1, 1, 32'h100, 32'h6660_0013);
        tbl[12] = mk(0, 0, 32'h000, 32'h0,         1, 0, 0, 1, 32'h000, NOP);

        RST_N = 1'b0; FLUSH = 1'b0; IMEM_VALID = 1'b0; IMEM_PC = 32'h0;
        IMEM_IR = 32'h0; ID_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cnt",   32'(COUNT), 32'd0);
        chk("rst_valid", 32'(ID_VALID), 32'd0);
        chk("rst_ready", 32'(IMEM_READY), 32'd1);
        chk("rst_pc",    ID_PC, 32'h0);
        chk("rst_ir",    ID_IR, NOP);
        RST_N = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ir, tbl[i].idr);
            chk($sformatf("t%0d_cnt", i),   32'(COUNT), tbl[i].e_cnt);
            chk($sformatf("t%0d_valid", i), 32'(ID_VALID), 32'(tbl[i].e_v));
            chk($sformatf("t%0d_ready", i), 32'(IMEM_READY), 32'(tbl[i].e_rdy));
            chk($sformatf("t%0d_pc", i),    ID_PC, tbl[i].e_pc);
            chk($sformatf("t%0d_ir", i),    ID_IR, tbl[i].e_ir);
        end

        // Wrap: 2*DEPTH+1 back-to-back transfers; head follows the input PC one cycle later.
        for (int k = 0; k < 2 * DEPTH + 1; k++) begin
            step(1'b0, 1'b1, 32'(4 * k), $urandom, 1'b1);
            chk($sformatf("wrap%0d_valid", k), 32'(ID_VALID), 32'd1);
            chk($sformatf("wrap%0d_pc", k), ID_PC, 32'(4 * k));
            check_model($sformatf("wrap%0d", k));
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_model("wrap_end");

        // Async reset mid-cycle with the queue full.
        step(1'b0, 1'b1, 32'h200, 32'hAAA0_0013, 1'b0);
        step(1'b0, 1'b1, 32'h204, 32'hBBB0_0013, 1'b0);
        chk("prerst_cnt", 32'(COUNT), 32'd2);
        IMEM_VALID = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        model.delete();
        chk("arst_valid", 32'(ID_VALID), 32'd0);
        chk("arst_ready", 32'(IMEM_READY), 32'd1);
        chk("arst_cnt",   32'(COUNT), 32'd0);
        chk("arst_ir",    ID_IR, NOP);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        step(1'b0, 1'b1, 32'h300, 32'hCCC0_0013, 1'b0);
        chk("postrst_pc", ID_PC, 32'h300);
        check_model("postrst");

        // Random traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 2) != 0));
            check_model($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_otter_fetch_queue
